// File: rtl/div_ctrl.sv
// div_ctrl: issue/retire control for the iterative divider core.
// Optional DIV_CTRL_REUSE_EN: one-entry cache of the last core result.
module div_ctrl #(
  parameter int WIDTH = 64
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_op,
  input  logic             i_word,
  input  logic [WIDTH-1:0] i_src1,
  input  logic [WIDTH-1:0] i_src2,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_div_start,
  output logic             o_div_flush,
  output logic             o_div_divw,
  output logic             o_div_signed,
  output logic [WIDTH-1:0] o_div_dividend,
  output logic [WIDTH-1:0] o_div_divisor,
  input  logic             i_div_busy,
  input  logic             i_div_end_valid,
  output logic             o_div_end_ready,
  input  logic [WIDTH-1:0] i_div_quotient,
  input  logic [WIDTH-1:0] i_div_remainder
);

  localparam int H = WIDTH / 2;
  localparam logic [H-1:0] MIN_H = {1'b1, {(H-1){1'b0}}};
  localparam logic [WIDTH-1:0] MIN_W = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e           state_q;
  logic [1:0]       op_q;
  logic             word_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic             divw_q;
  logic             sgn_q;

  logic             div0;
  logic             ovf;
  logic             special;
  logic [WIDTH-1:0] sp_quo;
  logic [WIDTH-1:0] sp_rem;
  logic             divw_d;
  logic             sgn_d;
  logic [WIDTH-1:0] dvd_d;
  logic [WIDTH-1:0] dvs_d;
  logic             hit;
  logic [WIDTH-1:0] hit_quo;
  logic [WIDTH-1:0] hit_rem;

  function automatic logic [WIDTH-1:0] pick(
    input logic [WIDTH-1:0] q,
    input logic [WIDTH-1:0] r,
    input logic             rem,
    input logic             w
  );
    logic [WIDTH-1:0] v;
    v = rem ? r : q;
    if (w) v = {{H{v[H-1]}}, v[H-1:0]};
    return v;
  endfunction

  always_comb begin
    div0 = i_word ? (i_src2[H-1:0] == '0)
                  : (i_src2 == '0);
    ovf  = ~i_op[0] & (i_word
         ? (i_src1[H-1:0] == MIN_H) & (&i_src2[H-1:0])
         : (i_src1 == MIN_W) & (&i_src2));
    special = div0 | ovf;
    sp_quo  = div0 ? '1 : i_src1;
    sp_rem  = div0 ? i_src1 : '0;
  end

  // The core's W mode sign-extends, so unsigned W runs as zero-extended 64-bit.
  always_comb begin
    divw_d = 1'b0;
    sgn_d  = ~i_op[0];
    dvd_d  = i_src1;
    dvs_d  = i_src2;
    unique case (1'b1)
      i_word & ~i_op[0]: begin
        divw_d = 1'b1;
        sgn_d  = 1'b1;
      end
      i_word & i_op[0]: begin
        sgn_d = 1'b0;
        dvd_d = {{H{1'b0}}, i_src1[H-1:0]};
        dvs_d = {{H{1'b0}}, i_src2[H-1:0]};
      end
      default: ;
    endcase
  end

`ifdef DIV_CTRL_REUSE_EN
  logic             c_vld_q;
  logic [WIDTH-1:0] c_s1_q;
  logic [WIDTH-1:0] c_s2_q;
  logic             c_word_q;
  logic             c_sgn_q;
  logic [WIDTH-1:0] c_quo_q;
  logic [WIDTH-1:0] c_rem_q;
  logic [WIDTH-1:0] src1_q;
  logic [WIDTH-1:0] src2_q;

  always_comb begin
    hit = c_vld_q & (i_src1 == c_s1_q)
        & (i_src2 == c_s2_q)
        & (i_word == c_word_q)
        & (~i_op[0] == c_sgn_q);
    hit_quo = c_quo_q;
    hit_rem = c_rem_q;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      c_vld_q <= 1'b0;
    end else if (state_q == IDLE && i_valid && o_ready) begin
      src1_q <= i_src1;
      src2_q <= i_src2;
    end else if (state_q == WAIT && i_div_end_valid) begin
      c_vld_q  <= 1'b1;
      c_s1_q   <= src1_q;
      c_s2_q   <= src2_q;
      c_word_q <= word_q;
      c_sgn_q  <= ~op_q[0];
      c_quo_q  <= i_div_quotient;
      c_rem_q  <= i_div_remainder;
    end
  end
`else
  always_comb begin
    hit     = 1'b0;
    hit_quo = '0;
    hit_rem = '0;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      word_q  <= 1'b0;
      res_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      divw_q  <= 1'b0;
      sgn_q   <= 1'b0;
    end else if (i_flush) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (i_valid && o_ready) begin
          op_q   <= i_op;
          word_q <= i_word;
          if (special) begin
            res_q   <= pick(sp_quo, sp_rem, i_op[1], i_word);
            state_q <= DONE;
          end else if (hit) begin
            res_q   <= pick(hit_quo, hit_rem, i_op[1], i_word);
            state_q <= DONE;
          end else begin
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            divw_q  <= divw_d;
            sgn_q   <= sgn_d;
            state_q <= ISSUE;
          end
        end
        ISSUE: state_q <= WAIT;
        WAIT: if (i_div_end_valid) begin
          res_q <= pick(i_div_quotient, i_div_remainder,
                        op_q[1], word_q);
          state_q <= DONE;
        end
        DONE: if (i_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready         = (state_q == IDLE) & ~i_div_busy;
  assign o_valid         = (state_q == DONE) & ~i_flush;
  assign o_result        = res_q;
  assign o_div_start     = (state_q == ISSUE);
  assign o_div_end_ready = (state_q == WAIT);
  assign o_div_flush     = i_flush | ~i_rst_n;
  assign o_div_divw      = divw_q;
  assign o_div_signed    = sgn_q;
  assign o_div_dividend  = dvd_q;
  assign o_div_divisor   = dvs_q;

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Issue/retire controller that sits directly upstream of the iterative radix-2 divider core in the EXU.
- Accepts RV64M DIV/DIVU/REM/REMU and their W forms from the EXU dispatch through a valid/ready handshake, and resolves the RISC-V special cases locally without starting the core.
- Issues all other operations to the core with operand formatting, collects quotient/remainder, and selects and sign-extends the architectural result.
- Presents the result downstream through a valid/ready handshake.

Parameters:
- WIDTH, 64, datapath width; must be even; W ops use WIDTH/2.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_flush  in  1  pipeline flush; kills the in-flight op
- i_valid  in  1  request valid
- o_ready  out  1  request accepted when i_valid & o_ready
- i_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- i_word  in  1  W-form op (32-bit)
- i_src1  in  WIDTH  dividend
- i_src2  in  WIDTH  divisor
- o_valid  out  1  result valid
- i_ready  in  1  result consumed when o_valid & i_ready
- o_result  out  WIDTH  architectural result
- o_div_start  out  1  one-cycle start pulse to core
- o_div_flush  out  1  flush to core
- o_div_divw  out  1  core 32-bit mode
- o_div_signed  out  1  core signed mode
- o_div_dividend  out  WIDTH  core dividend
- o_div_divisor  out  WIDTH  core divisor
- i_div_busy  in  1  core busy
- i_div_end_valid  in  1  core result valid
- o_div_end_ready  out  1  core result accept
- i_div_quotient  in  WIDTH  core quotient
- i_div_remainder  in  WIDTH  core remainder

Behaviour:
- Reset (sync, active-low): state IDLE; all outputs 0 except o_ready, which follows its equation (1 if ~i_div_busy).
- States: IDLE, ISSUE, WAIT, DONE.
- o_ready = (state==IDLE) & ~i_div_busy.
- Accept: latch op, word, operands.
- Latched special case, op done locally:
  - divisor==0: quotient = all ones; remainder = dividend.
  - Signed overflow (dividend == most negative, divisor == -1, at the op width): quotient = dividend; remainder = 0.
  - Result selected; state -> DONE; o_valid rises the next cycle (latency 1).
  - o_div_start is never asserted.
- Otherwise: IDLE -> ISSUE, and o_div_start = 1 for exactly one cycle in ISSUE. Core operands by op class:
  - Signed W: o_div_divw = 1, o_div_signed = 1, raw operands.
  - Unsigned W: o_div_divw = 0, o_div_signed = 0, operands zero-extended from bit WIDTH/2-1. The core's W mode sign-extends its inputs, so unsigned W ops must not use it.
  - 64-bit ops: divw = 0, signed = ~i_op[0].
- ISSUE -> WAIT. o_div_end_ready = 1 only in WAIT.
  - When i_div_end_valid is seen in WAIT, capture quotient or remainder (per i_op[1]) into the result register and go to DONE.
- W ops: o_result = sign-extension of bit WIDTH/2-1 of the selected value, for every path, including special cases.
- DONE: o_valid = 1, o_result stable. On i_ready, go to IDLE; o_ready may assert the same cycle only if the core is not busy.
- i_flush in any state:
  - Next state IDLE, o_valid = 0, o_div_flush = i_flush (combinational).
  - A core completion arriving in the flush cycle is discarded.
  - Flush has priority over accept in the same cycle.
- Reset mid-operation behaves like flush and also drives o_div_flush.
- Result registers hold when not in DONE. o_result is don't-care when o_valid = 0, but is driven 0 after reset.

Optional Feature:
- DIV_CTRL_REUSE_EN: a one-entry cache of the last completed core op, storing {src1, src2, word, signed-ness, quotient, remainder}.
- With the macro defined, a new request that matches all keys skips the core: it goes directly to DONE with latency 1. This covers e.g. DIV followed by REM on the same operands.
- The cache is invalidated on reset and flush, and is never filled by special-case results.
- Without the macro: no cache storage, and every non-special op uses the core.

Test Plan:
- DIV src1 = 0xFFFF_FFFF_FFFF_FFF9 (-7), src2 = 2 -> o_result 0xFFFF_FFFF_FFFF_FFFD; REM on the same operands -> 0xFFFF_FFFF_FFFF_FFFF. o_div_start pulses once per op.
- DIVU src1 = 0x1234, src2 = 0 -> o_result 0xFFFF_FFFF_FFFF_FFFF one cycle after accept, o_div_start never high; REMU on the same operands -> 0x1234.
- DIVW src1 = 0x0000_0000_8000_0000, src2 = 0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_8000_0000, no core start; REMW -> 0.
- DIVUW src1 = 0x0000_0000_FFFF_FFFE, src2 = 1:
  - Core sees divw = 0, signed = 0, dividend 0x0000_0000_FFFF_FFFE.
  - o_result 0xFFFF_FFFF_FFFF_FFFE.
  - REMUW 0xFFFF_FFFF / 0x10 -> 0xF.
- Flush two cycles after start -> o_div_flush high, no o_valid, o_ready returns; the next DIV 100/7 -> 14.
- Backpressure: hold i_ready = 0 for 10 cycles in DONE -> o_valid and o_result stable, o_ready = 0. With DIV_CTRL_REUSE_EN, a REM following a DIV on the same operands completes in 1 cycle with no start pulse.
